mole_round_ctrl: RTL and testbench

Game-round controller for the whack-a-mole datapath: consumer of the 3-bit LFSR box selector. Per round it steps the LFSR once, maps the state non-uniformly to one of four boxes, and lights that box until a key hit or a tick-based timeout. It scores hits, counts misses, and ends the game after a configurable miss limit. It sits between `lfsr_3bit` and the LED/HEX display logic.

---
 rtl/mole_pkg.sv | 21 ++
 rtl/mole_box_map.sv | 25 ++
 rtl/mole_round_ctrl.sv | 167 ++++++++++++++++
 tb/tb_mole_round_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mole_pkg.sv
// Shared constants for the whack-a-mole round controller and its box mapper.
package mole_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_DRAW   = 3'd1;
    localparam state_t ST_SAMPLE = 3'd2;
    localparam state_t ST_SHOW   = 3'd3;
    localparam state_t ST_HIT    = 3'd4;
    localparam state_t ST_MISS   = 3'd5;
    localparam state_t ST_OVER   = 3'd6;

    localparam logic [3:0] BOX1 = 4'b0001;
    localparam logic [3:0] BOX2 = 4'b0010;
    localparam logic [3:0] BOX3 = 4'b0100;
    localparam logic [3:0] BOX4 = 4'b1000;

    localparam int unsigned REDRAW_LIMIT = 3;

endpackage

// File: rtl/mole_box_map.sv
// Non-uniform LFSR state to one-hot box mapping; state 000 is reported invalid.
module mole_box_map
    import mole_pkg::*;
(
    input  logic [2:0] lfsr_state,
    output logic       valid,
    output logic [3:0] box
);

    always_comb begin
        valid = 1'b1;
        box   = BOX1;
        case (lfsr_state)
            3'b001, 3'b010, 3'b100: box = BOX1;
            3'b011, 3'b101:         box = BOX2;
            3'b110:                 box = BOX3;
            3'b111:                 box = BOX4;
            default: begin
                valid = 1'b0;
                box   = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/mole_round_ctrl.sv
// Whack-a-mole round controller: draws a box from the LFSR, lights it, scores hits and misses.
// Optional MOLE_STREAK_BONUS_EN: the third and later consecutive hits score 2 instead of 1.
module mole_round_ctrl
    import mole_pkg::*;
#(
    parameter int unsigned MOLE_TICKS = 500,
    parameter int unsigned MAX_MISSES = 5,
    parameter int unsigned SCORE_W    = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               tick,
    input  logic [2:0]         lfsr_state,
    input  logic [3:0]         key_hit,
    output logic               lfsr_enable,
    output logic [3:0]         mole_box,
    output logic [SCORE_W-1:0] score,
    output logic [3:0]         misses,
    output logic               round_done,
    output logic               game_over
);

    localparam int unsigned TICK_W = (MOLE_TICKS > 1) ? $clog2(MOLE_TICKS) : 1;

    state_t             state_q, state_d;
    logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
    logic [1:0]         redraw_q, redraw_d;
    logic [3:0]         box_q, box_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [3:0]         misses_q, misses_d;
    logic               round_done_q, round_done_d;
    logic [SCORE_W:0]   score_inc, score_sum;
    logic               map_valid;
    logic [3:0]         map_box;

`ifdef MOLE_STREAK_BONUS_EN
    logic [1:0]         streak_q, streak_d;
`endif

    mole_box_map u_box_map (
        .lfsr_state (lfsr_state),
        .valid      (map_valid),
        .box        (map_box)
    );

    always_comb begin
        state_d      = state_q;
        tick_cnt_d   = tick_cnt_q;
        redraw_d     = redraw_q;
        box_d        = box_q;
        score_d      = score_q;
        misses_d     = misses_q;
        round_done_d = 1'b0;
        score_inc    = '0;
`ifdef MOLE_STREAK_BONUS_EN
        streak_d       = streak_q;
        score_inc[1:0] = (streak_q >= 2'd2) ? 2'd2 : 2'd1;
`else
        score_inc[0]   = 1'b1;
`endif
        score_sum = {1'b0, score_q} + score_inc;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    state_d  = ST_DRAW;
                    score_d  = '0;
                    misses_d = '0;
`ifdef MOLE_STREAK_BONUS_EN
                    streak_d = '0;
`endif
                end
            end
            ST_DRAW: state_d = ST_SAMPLE;
            ST_SAMPLE: begin
                if (map_valid) begin
                    box_d      = map_box;
                    tick_cnt_d = '0;
                    redraw_d   = '0;
                    state_d    = ST_SHOW;
                end else if (redraw_q == 2'(REDRAW_LIMIT - 1)) begin
                    // Bound the LFSR lock-up case: give up redrawing and use box 1
                    box_d      = BOX1;
                    tick_cnt_d = '0;
                    redraw_d   = '0;
                    state_d    = ST_SHOW;
                end else begin
                    redraw_d = redraw_q + 2'd1;
                    state_d  = ST_DRAW;
                end
            end
            ST_SHOW: begin
                if ((key_hit & box_q) != 4'b0000) begin
                    state_d = ST_HIT;
                end else if (key_hit != 4'b0000) begin
                    state_d = ST_MISS;
                end else if (tick) begin
                    if (tick_cnt_q == TICK_W'(MOLE_TICKS - 1)) begin
                        state_d = ST_MISS;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            ST_HIT: begin
                score_d      = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
                box_d        = '0;
                round_done_d = 1'b1;
                state_d      = ST_DRAW;
`ifdef MOLE_STREAK_BONUS_EN
                if (streak_q != 2'd3) begin
                    streak_d = streak_q + 2'd1;
                end
`endif
            end
            ST_MISS: begin
                misses_d     = misses_q + 4'd1;
                box_d        = '0;
                round_done_d = 1'b1;
`ifdef MOLE_STREAK_BONUS_EN
                streak_d     = '0;
`endif
                state_d      = (misses_q + 4'd1 == 4'(MAX_MISSES)) ? ST_OVER : ST_DRAW;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            tick_cnt_q   <= '0;
            redraw_q     <= '0;
            box_q        <= '0;
            score_q      <= '0;
            misses_q     <= '0;
            round_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            redraw_q     <= redraw_d;
            box_q        <= box_d;
            score_q      <= score_d;
            misses_q     <= misses_d;
            round_done_q <= round_done_d;
        end
    end

`ifdef MOLE_STREAK_BONUS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end
`endif

    assign lfsr_enable = (state_q == ST_DRAW);
    assign game_over   = (state_q == ST_OVER);
    assign mole_box    = box_q;
    assign score       = score_q;
    assign misses      = misses_q;
    assign round_done  = round_done_q;

endmodule

// File: tb/tb_mole_round_ctrl.sv
// Directed plus randomized bench for mole_round_ctrl against a round-level scoring model.
module tb_mole_round_ctrl;

    localparam int MOLE_TICKS = 4;
    localparam int MAX_MISSES = 5;
    localparam int SCORE_W    = 8;
    localparam int SCORE_MAX  = 255;
    localparam int REDRAWS    = 3;

`ifdef MOLE_STREAK_BONUS_EN
    localparam bit STREAK_EN = 1'b1;
`else
    localparam bit STREAK_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               start = 1'b0;
    logic               tick = 1'b0;
    logic [2:0]         lfsr_state = 3'b000;
    logic [3:0]         key_hit = 4'b0000;
    logic               lfsr_enable;
    logic [3:0]         mole_box;
    logic [SCORE_W-1:0] score;
    logic [3:0]         misses;
    logic               round_done;
    logic               game_over;

    int n_checks = 0;
    int n_fail   = 0;

    // Round-level reference model
    int         exp_score;
    int         exp_misses;
    int         streak;
    bit         exp_over;
    logic [3:0] cur_box;
    logic [3:0] box_tbl [8];

    mole_round_ctrl #(
        .MOLE_TICKS (MOLE_TICKS),
        .MAX_MISSES (MAX_MISSES),
        .SCORE_W    (SCORE_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .tick        (tick),
        .lfsr_state  (lfsr_state),
        .key_hit     (key_hit),
        .lfsr_enable (lfsr_enable),
        .mole_box    (mole_box),
        .score       (score),
        .misses      (misses),
        .round_done  (round_done),
        .game_over   (game_over)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no end of test, required end before 500000");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_checks++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
        end
    endtask

    task automatic model_clear();
        exp_score  = 0;
        exp_misses = 0;
        streak     = 0;
        exp_over   = 1'b0;
    endtask

    task automatic model_hit();
        int inc;
        inc = (STREAK_EN && streak >= 2) ? 2 : 1;
        exp_score = (exp_score + inc > SCORE_MAX) ? SCORE_MAX : exp_score + inc;
        streak++;
    endtask

    task automatic model_miss();
        exp_misses++;
        streak   = 0;
        exp_over = (exp_misses == MAX_MISSES);
    endtask

    // Precondition: DRAW cycle visible. Leaves the first SHOW cycle visible.
    task automatic enter_round(input int n_zero, input logic [2:0] ls);
        int   pulses;
        int   k;
        bit   shown;
        int   exp_pulses;
        check("draw_enable", lfsr_enable, 1);
        pulses     = 1;
        k          = 0;
        shown      = 1'b0;
        exp_pulses = ((n_zero < REDRAWS - 1) ? n_zero : REDRAWS - 1) + 1;
        cur_box    = (n_zero >= REDRAWS) ? 4'b0001 : box_tbl[ls];
        for (int it = 0; it < 8 && !shown; it++) begin
            lfsr_state = (k < n_zero) ? 3'b000 : ls;
            key_hit    = 4'($urandom);
            tick       = 1'($urandom);
            cyc();
            key_hit = 4'($urandom);
            tick    = 1'($urandom);
            check("sample_dark", mole_box, 0);
            check("round_done_pulse", round_done, 0);
            cyc();
            key_hit = 4'b0000;
            tick    = 1'b0;
            k++;
            if (mole_box != 4'b0000) shown = 1'b1;
            else if (lfsr_enable) pulses++;
            else break;
        end
        check("draw_pulses", pulses, exp_pulses);
        check("mole_box", mole_box, cur_box);
    endtask

    task automatic show_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            cyc();
            tick = 1'b0;
            check("show_lit", mole_box, cur_box);
        end
    endtask

    task automatic hit_round(input int pre_ticks, input logic [3:0] keys, input logic tk);
        show_ticks(pre_ticks);
        key_hit = keys;
        tick    = tk;
        cyc();
        key_hit = 4'b0000;
        tick    = 1'b0;
        check("hit_hold_box", mole_box, cur_box);
        check("hit_hold_done", round_done, 0);
        cyc();
        model_hit();
        check("hit_score", score, exp_score);
        check("hit_misses", misses, exp_misses);
        check("hit_round_done", round_done, 1);
        check("hit_box_clear", mole_box, 0);
        check("hit_game_over", game_over, 0);
        check("hit_next_draw", lfsr_enable, 1);
    endtask

    task automatic finish_miss();
        check("miss_hold_box", mole_box, cur_box);
        cyc();
        model_miss();
        check("miss_box_clear", mole_box, 0);
        check("miss_count", misses, exp_misses);
        check("miss_score_hold", score, exp_score);
        check("miss_round_done", round_done, 1);
        check("miss_game_over", game_over, exp_over);
        check("miss_next_draw", lfsr_enable, !exp_over);
    endtask

    task automatic miss_key_round(input int pre_ticks);
        logic [3:0] kk;
        do kk = 4'($urandom_range(1, 15)) & ~cur_box; while (kk == 4'b0000);
        show_ticks(pre_ticks);
        key_hit = kk;
        cyc();
        key_hit = 4'b0000;
        finish_miss();
    endtask

    task automatic timeout_round();
        for (int i = 0; i < MOLE_TICKS; i++) begin
            repeat ($urandom_range(0, 2)) begin
                cyc();
                check("timeout_gap_lit", mole_box, cur_box);
            end
            tick = 1'b1;
            cyc();
            tick = 1'b0;
        end
        finish_miss();
    endtask

    task automatic restart();
        check("over_level", game_over, 1);
        start = 1'b1;
        cyc();
        start = 1'b0;
        model_clear();
        check("restart_draw", lfsr_enable, 1);
        check("restart_score", score, 0);
        check("restart_misses", misses, 0);
        check("restart_over", game_over, 0);
    endtask

    initial begin
        box_tbl[0] = 4'b0000;
        box_tbl[1] = 4'b0001;
        box_tbl[2] = 4'b0001;
        box_tbl[3] = 4'b0010;
        box_tbl[4] = 4'b0001;
        box_tbl[5] = 4'b0010;
        box_tbl[6] = 4'b0100;
        box_tbl[7] = 4'b1000;
        model_clear();

        // Asynchronous reset, before any clock edge
        #1 reset = 1'b1;
        #2;
        check("rst_enable", lfsr_enable, 0);
        check("rst_box", mole_box, 0);
        check("rst_score", score, 0);
        check("rst_misses", misses, 0);
        check("rst_done", round_done, 0);
        check("rst_over", game_over, 0);
        cyc();
        cyc();
        reset = 1'b0;

        // Keys and ticks in IDLE do nothing
        key_hit = 4'hf;
        tick    = 1'b1;
        repeat (3) begin
            cyc();
            check("idle_box", mole_box, 0);
            check("idle_enable", lfsr_enable, 0);
            check("idle_score", score, 0);
        end
        key_hit = 4'h0;
        tick    = 1'b0;

        // First round with lfsr_state 110 held
        lfsr_state = 3'b110;
        start      = 1'b1;
        cyc();
        check("start_draw", lfsr_enable, 1);
        start = 1'b0;
        cyc();
        check("start_sample_enable", lfsr_enable, 0);
        check("start_sample_box", mole_box, 0);
        cyc();
        check("start_box3", mole_box, 4'b0100);
        cur_box = 4'b0100;
        hit_round(0, 4'b0100, 1'b0);

        enter_round(0, 3'b011);
        hit_round(1, 4'b0010, 1'b0);
        enter_round(0, 3'b101);
        hit_round(2, 4'b0011, 1'b0);
        enter_round(0, 3'b111);
        hit_round(0, 4'b1000, 1'b0);
        enter_round(0, 3'($urandom_range(1, 7)));
        miss_key_round(1);
        enter_round(0, 3'($urandom_range(1, 7)));
        hit_round(0, cur_box, 1'b0);

        // Correct hit in the same cycle as the timeout tick
        enter_round(0, 3'($urandom_range(1, 7)));
        hit_round(MOLE_TICKS - 1, cur_box, 1'b1);

        // Redraw on 000, forced box 1 on the third
        enter_round(3, 3'($urandom_range(1, 7)));
        hit_round(0, cur_box, 1'b0);
        enter_round(2, 3'($urandom_range(1, 7)));
        hit_round(0, cur_box, 1'b0);
        enter_round(2, 3'($urandom_range(1, 7)));
        timeout_round();
        enter_round(1, 3'($urandom_range(1, 7)));
        hit_round(0, cur_box | 4'($urandom), 1'b0);

        // Random rounds
        for (int r = 0; r < 30; r++) begin
            int nz;
            int act;
            nz  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            act = int'($urandom_range(0, 3));
            enter_round(nz, 3'($urandom_range(1, 7)));
            if (act < 2) hit_round(int'($urandom_range(0, MOLE_TICKS - 1)),
                                   cur_box | 4'($urandom), 1'($urandom));
            else if (act == 2) miss_key_round(int'($urandom_range(0, MOLE_TICKS - 1)));
            else timeout_round();
            if (exp_over) restart();
        end

        // Timeouts to game over, then exactly MAX_MISSES timeouts after a restart
        for (int g = 0; g < 16 && !exp_over; g++) begin
            enter_round(0, 3'($urandom_range(1, 7)));
            timeout_round();
        end
        restart();
        for (int g = 0; g < MAX_MISSES; g++) begin
            enter_round(0, 3'($urandom_range(1, 7)));
            timeout_round();
        end
        check("over_after_limit", game_over, 1);
        repeat (4) begin
            key_hit = 4'($urandom);
            tick    = 1'($urandom);
            cyc();
            check("over_hold", game_over, 1);
            check("over_misses", misses, MAX_MISSES);
            check("over_box", mole_box, 0);
            check("over_enable", lfsr_enable, 0);
        end
        key_hit = 4'b0000;
        tick    = 1'b0;
        restart();

        // Saturation
        for (int h = 0; h < SCORE_MAX + 4; h++) begin
            enter_round(0, 3'($urandom_range(1, 7)));
            hit_round(0, cur_box, 1'b0);
        end
        check("score_saturated", score, SCORE_MAX);

        // Asynchronous reset in the middle of a round
        enter_round(0, 3'($urandom_range(1, 7)));
        #2 reset = 1'b1;
        #1;
        model_clear();
        check("midrst_box", mole_box, 0);
        check("midrst_score", score, 0);
        check("midrst_done", round_done, 0);
        check("midrst_enable", lfsr_enable, 0);
        cyc();
        reset = 1'b0;
        repeat (2) begin
            cyc();
            check("midrst_no_done", round_done, 0);
            check("midrst_idle", lfsr_enable, 0);
        end
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("midrst_restart", lfsr_enable, 1);
        enter_round(0, 3'b001);
        hit_round(0, 4'b0001, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
